// File: rtl/rf_write_arbiter_if.sv
// Request/write-port bundle between writeback requesters, the arbiter and the register bank.
interface rf_write_arbiter_if #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_LENGTH = 32,
  parameter int REGS_QTY    = 32
);
  localparam int ADDR_W = $clog2(REGS_QTY);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*ADDR_W-1:0]      req_addr;
  logic [NUM_REQ*DATA_LENGTH-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           rf_hold;
  logic [DATA_LENGTH-1:0]         rf_d;
  logic [REGS_QTY-1:0]            rf_en;
  logic                           pend_valid;
  logic [ADDR_W-1:0]              pend_addr;

  modport master (
    output req_valid, req_addr, req_data, rf_hold,
    input  req_ready, rf_d, rf_en, pend_valid, pend_addr
  );

  modport slave (
    input  req_valid, req_addr, req_data, rf_hold,
    output req_ready, rf_d, rf_en, pend_valid, pend_addr
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the register bank's single write port.
// Optional RF_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority.
module rf_write_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_LENGTH = 32,
  parameter int REGS_QTY    = 32
) (
  input  logic                clk,
  input  logic                rst,
  rf_write_arbiter_if.slave   bus
);
  localparam int ADDR_W = $clog2(REGS_QTY);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                   valid_q, valid_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;

  logic                   grant_any;
  logic [IDX_W-1:0]       grant_idx;
  logic                   accept;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_LENGTH-1:0] sel_data;
  logic                   pend_valid;

  logic [ADDR_W-1:0]      addr_arr [NUM_REQ];
  logic [DATA_LENGTH-1:0] data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]      = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi]      = bus.req_data[gi*DATA_LENGTH +: DATA_LENGTH];
      assign bus.req_ready[gi] = accept && (grant_idx == IDX_W'(gi));
    end
  endgenerate

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               dist;
  int               best;

  // Winner is the valid requester at the smallest circular distance from the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    best      = NUM_REQ;
    dist      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      dist = (k + NUM_REQ - int'(ptr_q)) % NUM_REQ;
      if (bus.req_valid[k] && (dist < best)) begin
        best      = dist;
        grant_any = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (int'(grant_idx) == NUM_REQ - 1) ptr_d = '0;
      else                                ptr_d = grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scanning downward leaves the lowest-index valid requester selected.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end
`endif

  assign accept = grant_any && !bus.rf_hold;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_addr = addr_arr[k];
        sel_data = data_arr[k];
      end
    end
  end

  // Hold freezes the stage entirely; otherwise an unrefilled stage just drops valid.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      addr_d  = sel_addr;
      data_d  = sel_data;
    end else if (!bus.rf_hold) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Writes to x0 are absorbed: no enable and no hazard report.
  assign pend_valid     = valid_q && (addr_q != '0);
  assign bus.pend_valid = pend_valid;
  assign bus.pend_addr  = addr_q;
  assign bus.rf_d       = data_q;

  always_comb begin
    bus.rf_en = '0;
    if (pend_valid && !bus.rf_hold) bus.rf_en[addr_q] = 1'b1;
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a per-cycle spec model plus hand-computed literal expectations.
module tb_rf_write_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int RQ = 32;
`ifdef RF_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.NUM_REQ(N), .DATA_LENGTH(DW), .REGS_QTY(RQ)) bus ();
  rf_write_arbiter #(.NUM_REQ(N), .DATA_LENGTH(DW), .REGS_QTY(RQ)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Spec model: one pending write slot, a round-robin pointer and the last staged data.
  bit          model_known = 1'b0;
  bit          m_valid;
  int          m_addr;
  logic [31:0] m_data;
  int          m_ptr;
  int          w;
  logic [N-1:0]  er;
  logic [31:0]   een;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = RR ? (ptr + k) % N : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    w  = bus.rf_hold ? -1 : pick(bus.req_valid, m_ptr);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    een = '0;
    if (m_valid && !bus.rf_hold && m_addr != 0) een[m_addr] = 1'b1;
    if (model_known) begin
      check("model req_ready", 32'(bus.req_ready), 32'(er));
      check("model rf_en", bus.rf_en, een);
      check("model rf_d", bus.rf_d, m_data);
      check("model pend_valid", 32'(bus.pend_valid), 32'(m_valid && m_addr != 0));
      check("model pend_addr", 32'(bus.pend_addr), 32'(m_addr));
    end
    if (rst) begin
      m_valid = 1'b0; m_addr = 0; m_data = '0; m_ptr = 0;
      model_known = 1'b1;
    end else if (model_known) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_addr  = int'(bus.req_addr[w*5 +: 5]);
        m_data  = bus.req_data[w*DW +: DW];
        m_ptr   = (w + 1) % N;
        $display("xfer: req %0d -> x%0d data 0x%08h", w, m_addr, m_data);
      end else if (!bus.rf_hold) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1, input logic h);
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
    bus.rf_hold   = h;
  endtask

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] exp_en;
    rst = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    step(); step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset rf_en", bus.rf_en, 32'h0);
    check("reset rf_d", bus.rf_d, 32'h0);
    check("reset pend_valid", 32'(bus.pend_valid), 32'h0);
    check("reset pend_addr", 32'(bus.pend_addr), 32'h0);

    // Single write to x5
    step();
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("single ready", 32'(bus.req_ready), 32'h1);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("single rf_en", bus.rf_en, 32'h0000_0020);
    check("single rf_d", bus.rf_d, 32'hDEADBEEF);
    check("single pend_valid", 32'(bus.pend_valid), 32'h1);
    check("single pend_addr", 32'(bus.pend_addr), 32'd5);
    step();
    @(negedge clk);
    check("single rf_en idle", bus.rf_en, 32'h0);

    // Reset to clear the pointer, then 4 cycles of contention
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2, 1'b0);
      else       drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
      @(negedge clk);
      if (i < 4) begin
        exp_g = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
        check("contend ready", 32'(bus.req_ready), 32'(exp_g));
      end
      if (i > 0) begin
        exp_en = (RR && ((i - 1) % 2 == 1)) ? 32'h4 : 32'h2;
        check("contend rf_en", bus.rf_en, exp_en);
      end
      step();
    end

    // Hold: stage x7 from requester 1, then hold for 3 cycles
    drive(2'b10, 5'd0, 32'h0, 5'd7, 32'h77, 1'b0);
    @(negedge clk);
    check("hold stage ready", 32'(bus.req_ready), 32'h2);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 5'd10, 32'hAA, 5'd11, 32'hBB, 1'b1);
      @(negedge clk);
      check("hold rf_en", bus.rf_en, 32'h0);
      check("hold ready", 32'(bus.req_ready), 32'h0);
      check("hold pend_addr", 32'(bus.pend_addr), 32'd7);
      check("hold pend_valid", 32'(bus.pend_valid), 32'h1);
      step();
    end
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("hold release rf_en", bus.rf_en, 32'h80);
    check("hold release rf_d", bus.rf_d, 32'h77);
    step();

    // x0 write from requester 0, then one contention cycle to expose the pointer
    drive(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("x0 ready", 32'(bus.req_ready), 32'h1);
    step();
    drive(2'b11, 5'd20, 32'hC0, 5'd21, 32'hC1, 1'b0);
    @(negedge clk);
    check("x0 rf_en", bus.rf_en, 32'h0);
    check("x0 pend_valid", 32'(bus.pend_valid), 32'h0);
    check("x0 rf_d", bus.rf_d, 32'h12345678);
    check("x0 ptr ready", 32'(bus.req_ready), RR ? 32'h2 : 32'h1);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("x0 ptr rf_en", bus.rf_en, RR ? 32'h0020_0000 : 32'h0010_0000);
    step();

    // Reset mid-operation
    drive(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("rstmid ready", 32'(bus.req_ready), 32'h1);
    step();
    rst = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("rstmid pre rf_en", bus.rf_en, 32'h200);
    step();
    rst = 1'b0;
    drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2, 1'b0);
    @(negedge clk);
    check("rstmid rf_en", bus.rf_en, 32'h0);
    check("rstmid pend_valid", 32'(bus.pend_valid), 32'h0);
    check("rstmid rf_d", bus.rf_d, 32'h0);
    check("rstmid ptr ready", 32'(bus.req_ready), 32'h1);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    step();

    // Back-to-back from requester 1: x3, x4, x5
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(2'b10, 5'd0, 32'h0, 5'(3 + i), 32'h33 + 32'(i * 'h11), 1'b0);
      else       drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
      @(negedge clk);
      if (i < 3) check("b2b ready", 32'(bus.req_ready), 32'h2);
      if (i > 0) begin
        check("b2b rf_en", bus.rf_en, 32'h8 << (i - 1));
        check("b2b rf_d", bus.rf_d, 32'h33 + 32'((i - 1) * 'h11));
      end
      step();
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register bank's single write port (32-bit data plus 32-bit one-hot enable) between NUM_REQ writeback requesters, e.g. the ALU/load writeback and a multicycle unit.
- Arbitrates valid/ready requests and registers the winner into one output stage.
- Drives the bank's data input and enable vector for exactly one cycle per accepted write.
- Exports the in-flight destination for hazard logic.

Parameters:
- NUM_REQ, 2, number of requester ports (2..4).
- DATA_LENGTH, 32, write data width.
- REGS_QTY, 32, registers in the bank; address width is clog2(REGS_QTY) = 5.

Ports:
- clk  input  1  clock; everything updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  requester i has a write pending.
- req_addr  input  NUM_REQ*5  destination register; slice i is [5i+4:5i].
- req_data  input  NUM_REQ*DATA_LENGTH  write data; slice i is [32i+31:32i].
- req_ready  output  NUM_REQ  one-hot grant; transfer occurs when valid&ready.
- rf_hold  input  1  freezes the output stage and blocks all grants.
- rf_d  output  DATA_LENGTH  to the bank's data input.
- rf_en  output  REGS_QTY  one-hot to the bank's enable input; all-zero when idle.
- pend_valid  output  1  a non-x0 write is in the output stage.
- pend_addr  output  5  destination of that write.

Behaviour:
- Reset (rst=1 at an edge) clears:
  - stage valid to 0, stage addr to 0, stage data to 0;
  - rf_en to 0, rf_d to 0, pend_valid to 0, pend_addr to 0;
  - round-robin pointer to 0.
- Reset mid-operation discards any staged write; no enable is asserted in the cycle after reset.
- Arbitration is combinational over req_valid; at most one grant per cycle.
  - With rf_hold=1, req_ready is all-zero.
  - Otherwise req_ready[i]=1 only for the selected valid requester.
  - req_ready never asserts for a requester whose req_valid=0.
- Latency: handshake in cycle N gives rf_en one-hot at bit req_addr and rf_d=req_data during cycle N+1. The bank captures at the end of N+1.
- Output stage:
  - On accept: load addr/data, valid=1.
  - Else if rf_hold=0: valid=0, data and addr retained.
  - Else (rf_hold=1): hold all contents unchanged.
- Throughput is one write per cycle with back-to-back grants.
- rf_en = (valid & ~rf_hold) ? onehot(addr) : 0. With rf_hold=1 the bank is never enabled; the staged write issues in the first cycle after rf_hold falls.
- rf_d always reflects stage data. Stage data is not zeroed when the stage empties.
- x0 writes:
  - Accepted normally (req_ready asserts, pointer advances).
  - rf_en stays all-zero and pend_valid=0.
- pend_valid = valid & (addr!=0); pend_addr = addr.
- Requesters must hold valid/addr/data stable until ready. Dropping valid before the grant is legal and is simply not granted.
- Simultaneous requests to the same register from two requesters are serialized in grant order; the later grant wins the register's final value.
- Requester port indices at or above NUM_REQ do not exist; the 5-bit address always decodes within 0..31.

Optional Feature:
- Macro: RF_ARB_ROUND_ROBIN_EN.
- Defined (round-robin):
  - Search starts at the pointer index and wraps modulo NUM_REQ.
  - On each accepted transfer the pointer becomes (granted index + 1) mod NUM_REQ.
  - The pointer is unchanged when nothing is accepted or when rf_hold=1.
- Undefined (fixed priority):
  - The lowest-index valid requester wins.
  - No pointer register exists.
  - Requester 0 can starve others.

Test Plan:
- Single write: after reset, req_valid=01, req_addr[0]=5, req_data[0]=0xDEADBEEF. Required: req_ready=01 in cycle N; rf_en=0x00000020 and rf_d=0xDEADBEEF in N+1; rf_en=0 in N+2; pend_valid=1 and pend_addr=5 during N+1.
- Contention, NUM_REQ=2, both valid for 4 cycles, addr0=1, addr1=2:
  - RF_ARB_ROUND_ROBIN_EN defined: grants 0,1,0,1; rf_en sequence 0x2,0x4,0x2,0x4 one cycle later.
  - Undefined: grants 0,0,0,0.
- Hold: a write to x7 is staged, then rf_hold=1 for 3 cycles with req_valid=11. Required: rf_en=0 and req_ready=00 throughout; pend_addr=7 is held; rf_en=0x80 in the first cycle after hold falls.
- x0 write: req_addr=0, data=0x12345678. Required: req_ready asserts; rf_en stays 0 and pend_valid stays 0 in N+1; the round-robin pointer advances.
- Reset mid-operation: handshake to x9 in cycle N, rst=1 during N+1. Required: rf_en=0x200 in N+1 only from the pre-reset stage; in N+2 rf_en=0, pend_valid=0, rf_d=0, and the pointer is 0 (next contention grants requester 0).
- Back-to-back: requester 1 alone writes x3,x4,x5 on consecutive cycles. Required: rf_en = 0x8, 0x10, 0x20 on consecutive cycles with matching rf_d and no bubbles.
